// File: rtl/stall_fifo_param_if.sv
// Handshake/data bundle between the upstream stage, the stall buffer and the downstream stage.
// The write side drives in_*, stall and flush; the buffer side drives out_* and the status flags.
interface stall_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow_err;

  modport master (
    output in_data, in_valid, stall, flush,
    input  out_data, out_valid, full, almost_full, empty, count, overflow_err
  );

  modport slave (
    input  in_data, in_valid, stall, flush,
    output out_data, out_valid, full, almost_full, empty, count, overflow_err
  );
endinterface

// File: rtl/stall_fifo_param.sv
// Stall buffer between two pipeline stages: soaks up words while stalled, drains them in order.
// Circular storage with wrapping pointers; all flags decode from the registered count.
module stall_fifo_param #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic               clk,
  input  logic               reset,
  stall_fifo_param_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              overflow_err;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              wr_en;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_W'(AFULL_THRESH));

  // Words enter storage while stalled (if room) or while draining; bypass never touches it.
  assign wr_en = !reset && !bus.flush && bus.in_valid && (bus.stall ? !full : !empty);

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      overflow_err <= 1'b0;
    end else if (bus.stall) begin
      out_valid <= 1'b0;
      if (bus.in_valid) begin
        if (!full) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          count  <= count + CNT_W'(1);
        end else begin
          overflow_err <= 1'b1;
        end
      end
    end else if (!empty) begin
      out_data  <= mem[rd_ptr];
      out_valid <= 1'b1;
      rd_ptr    <= rd_ptr + PTR_W'(1);
      // A concurrent write refills the slot just read, so occupancy stays put.
      if (bus.in_valid) wr_ptr <= wr_ptr + PTR_W'(1);
      else              count  <= count - CNT_W'(1);
    end else begin
      out_valid <= bus.in_valid;
      if (bus.in_valid) out_data <= bus.in_data;
    end
  end

  // Storage is not reset; a read of the slot being written returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_data;
  end

  assign bus.out_data     = out_data;
  assign bus.out_valid    = out_valid;
  assign bus.full         = full;
  assign bus.almost_full  = almost_full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.overflow_err = overflow_err;
endmodule

// File: tb/tb_stall_fifo_param.sv
// Bench for stall_fifo_param: DEPTH=8 and DEPTH=4 instances share stimulus and are each
// tracked by a queue-based model; directed table plus flush/reset/wrap sequences, then random.
module tb_stall_fifo_param;
  logic        clk = 1'b0;
  logic        reset, flush, stall, in_valid;
  logic [31:0] in_data;

  always #5 clk = ~clk;

  stall_fifo_param_if #(.DATA_W(32), .DEPTH(8)) bus8 ();
  stall_fifo_param_if #(.DATA_W(32), .DEPTH(4)) bus4 ();

  assign bus8.in_data = in_data;  assign bus4.in_data = in_data;
  assign bus8.in_valid = in_valid; assign bus4.in_valid = in_valid;
  assign bus8.stall = stall;      assign bus4.stall = stall;
  assign bus8.flush = flush;      assign bus4.flush = flush;

  stall_fifo_param #(.DATA_W(32), .DEPTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  stall_fifo_param #(.DATA_W(32), .DEPTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  logic [31:0] o_data [2];
  logic        o_valid [2], o_full [2], o_af [2], o_empty [2], o_ovf [2];
  logic [3:0]  o_count [2];
  assign o_data[0] = bus8.out_data;     assign o_data[1] = bus4.out_data;
  assign o_valid[0] = bus8.out_valid;   assign o_valid[1] = bus4.out_valid;
  assign o_full[0] = bus8.full;         assign o_full[1] = bus4.full;
  assign o_af[0] = bus8.almost_full;    assign o_af[1] = bus4.almost_full;
  assign o_empty[0] = bus8.empty;       assign o_empty[1] = bus4.empty;
  assign o_ovf[0] = bus8.overflow_err;  assign o_ovf[1] = bus4.overflow_err;
  assign o_count[0] = bus8.count;       assign o_count[1] = {1'b0, bus4.count};

  // Behavioural model: a plain queue of pending words plus the last presented output.
  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int D = (g == 0) ? 8 : 4;
    logic [31:0] q [$];
    logic [31:0] m_data = '0;
    logic        m_valid = 1'b0;
    logic        m_ovf = 1'b0;
    logic [3:0]  m_cnt = '0;
    always @(posedge clk) begin
      if (reset || flush) begin
        q.delete();
        m_data = '0; m_valid = 1'b0; m_ovf = 1'b0;
      end else if (stall) begin
        m_valid = 1'b0;
        if (in_valid) begin
          if (q.size() < D) q.push_back(in_data);
          else m_ovf = 1'b1;
        end
      end else if (q.size() > 0) begin
        m_data = q.pop_front();
        m_valid = 1'b1;
        if (in_valid) q.push_back(in_data);
      end else begin
        m_valid = in_valid;
        if (in_valid) m_data = in_data;
      end
      m_cnt = 4'(q.size());
    end
  end

  typedef struct {
    logic r, f, s, v;
    logic [31:0] d;
    logic ev;
    logic [31:0] ed;
    logic [3:0] ec;
    logic ef, ea, ee, eo;
  } vec_t;

  vec_t        tbl [$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic        collect = 1'b0;
  logic [31:0] sent [$];
  logic [31:0] got [$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic v, input logic [31:0] d, input logic [3:0] c,
                                       input logic f, input logic a, input logic e, input logic o);
    return {23'd0, v, d, c, f, a, e, o};
  endfunction

  task automatic check_models();
    cmp("model_d8", pack(o_valid[0], o_data[0], o_count[0], o_full[0], o_af[0], o_empty[0], o_ovf[0]),
        pack(g_model[0].m_valid, g_model[0].m_data, g_model[0].m_cnt, g_model[0].m_cnt == 8,
             g_model[0].m_cnt >= 6, g_model[0].m_cnt == 0, g_model[0].m_ovf));
    cmp("model_d4", pack(o_valid[1], o_data[1], o_count[1], o_full[1], o_af[1], o_empty[1], o_ovf[1]),
        pack(g_model[1].m_valid, g_model[1].m_data, g_model[1].m_cnt, g_model[1].m_cnt == 4,
             g_model[1].m_cnt >= 2, g_model[1].m_cnt == 0, g_model[1].m_ovf));
  endtask

  task automatic step(input logic r, input logic f, input logic s, input logic v, input logic [31:0] d);
    reset = r; flush = f; stall = s; in_valid = v; in_data = d;
    @(negedge clk);
    if (chk_en) check_models();
    if (collect && o_valid[1]) got.push_back(o_data[1]);
  endtask

  function automatic void add(input logic r, input logic f, input logic s, input logic v, input logic [31:0] d,
                              input logic ev, input logic [31:0] ed, input int ec,
                              input logic ef, input logic ea, input logic ee, input logic eo);
    vec_t x;
    x.r = r; x.f = f; x.s = s; x.v = v; x.d = d;
    x.ev = ev; x.ed = ed; x.ec = 4'(ec); x.ef = ef; x.ea = ea; x.ee = ee; x.eo = eo;
    tbl.push_back(x);
  endfunction

  initial begin
    // Directed table for the DEPTH=8 instance (almost_full threshold 6).
    add(1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 32'hA5A5_0001, 1, 32'hA5A5_0001, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 32'hA5A5_0001, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 1, 1, 32'(k), 0, 32'hA5A5_0001, k, k == 8, k >= 6, 0, 0);
    add(0, 0, 1, 1, 32'hDEAD_DEAD, 0, 32'hA5A5_0001, 8, 1, 1, 0, 1);
    for (int k = 1; k <= 4; k++)
      add(0, 0, 0, 1, 32'(8 + k), 1, 32'(k), 8, 1, 1, 0, 1);
    for (int j = 5; j <= 12; j++)
      add(0, 0, 0, 0, 32'h0, 1, 32'(j), 12 - j, 0, (12 - j) >= 6, j == 12, 1);
    add(0, 0, 0, 0, 32'h0, 0, 32'd12, 0, 0, 0, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].v, tbl[i].d);
      chk_en = 1'b1;
      cmp($sformatf("vec%0d", i),
          pack(o_valid[0], o_data[0], o_count[0], o_full[0], o_af[0], o_empty[0], o_ovf[0]),
          pack(tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].ef, tbl[i].ea, tbl[i].ee, tbl[i].eo));
    end

    // Flush mid-drain, overflow still set from the table.
    for (int k = 0; k < 6; k++) step(0, 0, 1, 1, 32'(100 + k));
    step(0, 0, 0, 0, 32'h0);
    cmp("pre_flush", pack(o_valid[0], o_data[0], o_count[0], 0, 0, 0, o_ovf[0]),
        pack(1, 32'd100, 5, 0, 0, 0, 1));
    step(0, 1, 0, 1, 32'hBEEF_0000);
    cmp("flush", pack(o_valid[0], o_data[0], o_count[0], o_full[0], o_af[0], o_empty[0], o_ovf[0]),
        pack(0, 32'h0, 0, 0, 0, 1, 0));

    // Reset mid-operation, then a bypass word one cycle later.
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 32'(200 + k));
    cmp("pre_reset_count", 64'(o_count[0]), 64'd3);
    step(1, 0, 1, 1, 32'h5555_5555);
    cmp("reset_mid", pack(o_valid[0], o_data[0], o_count[0], o_full[0], o_af[0], o_empty[0], o_ovf[0]),
        pack(0, 32'h0, 0, 0, 0, 1, 0));
    step(0, 0, 0, 1, 32'h0000_0077);
    cmp("post_reset_bypass", pack(o_valid[0], o_data[0], o_count[0], 0, 0, o_empty[0], 0),
        pack(1, 32'h77, 0, 0, 0, 1, 0));
    step(0, 0, 0, 0, 32'h0);

    // Wrap on the DEPTH=4 instance: 10 bursts of 3 buffered words, each drained before the next.
    collect = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 3; k++) begin
        sent.push_back(32'h3000_0000 + 32'(b * 3 + k));
        step(0, 0, 1, 1, 32'h3000_0000 + 32'(b * 3 + k));
      end
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 32'h0);
    end
    collect = 1'b0;
    cmp("wrap_len", 64'(got.size()), 64'(sent.size()));
    for (int i = 0; i < sent.size() && i < got.size(); i++)
      cmp($sformatf("wrap_word%0d", i), 64'(got[i]), 64'(sent[i]));

    // Random traffic against the models.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 7, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
